// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt responder.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] A_IMSK_DEF = 8'h3d;
    localparam logic [7:0] A_IPND_DEF = 8'h3c;
    localparam int unsigned ERR_BIT   = 7;

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module intc_prio_enc #(
    parameter int NSRC  = 4,
    parameter int VEC_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]  req,
    output logic             valid,
    output logic [VEC_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/intc_irq_responder.sv
// CPU-side responder: masks and arbitrates peripheral requests, presents a
// vector, and completes the interrupt_executed handshake after RETI.
module intc_irq_responder
    import intc_pkg::*;
#(
    parameter int          NSRC         = 4,
    parameter int          VEC_W        = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter logic [7:0]  A_IMSK       = A_IMSK_DEF,
    parameter logic [7:0]  A_IPND       = A_IPND_DEF,
    parameter int unsigned EXEC_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [7:0]       addr,
    input  logic [7:0]       wdata,
    input  logic             read,
    output logic [7:0]       rdata,
    input  logic [NSRC-1:0]  irq_req,
    output logic [NSRC-1:0]  irq_exec,
    input  logic             gie,
    output logic             cpu_irq,
    output logic [VEC_W-1:0] cpu_vec,
    input  logic             cpu_ack,
    input  logic             cpu_reti
);

    state_t            state_q, state_d;
    logic [NSRC-1:0]   imsk, imsk_d;
    logic [NSRC-1:0]   pend;
    logic              pend_valid;
    logic [VEC_W-1:0]  win;
    logic [VEC_W-1:0]  cur, cur_d;
    logic [VEC_W-1:0]  vec_d;
    logic              irq_d;
    logic [NSRC-1:0]   exec_d;
    logic [7:0]        cnt, cnt_d;
    logic              err, err_d;

    assign pend = irq_req & imsk;

    intc_prio_enc #(
        .NSRC  (NSRC),
        .VEC_W (VEC_W)
    ) u_prio_enc (
        .req   (pend),
        .valid (pend_valid),
        .idx   (win)
    );

    always_comb begin
        rdata = '0;
        if (read && addr == A_IMSK) begin
            rdata[NSRC-1:0] = imsk;
        end else if (read && addr == A_IPND) begin
            rdata[NSRC-1:0] = irq_req;
            rdata[ERR_BIT]  = err;
        end
    end

    always_comb begin
        state_d = state_q;
        imsk_d  = imsk;
        cur_d   = cur;
        vec_d   = cpu_vec;
        irq_d   = cpu_irq;
        exec_d  = irq_exec;
        cnt_d   = cnt;
        err_d   = err;

        if (write && addr == A_IMSK) imsk_d = wdata[NSRC-1:0];
        if (write && addr == A_IPND && wdata[ERR_BIT]) err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (gie && pend_valid) begin
                    state_d = REQ;
                    cur_d   = win;
                    vec_d   = win;
                    irq_d   = 1'b1;
                end
            end
            REQ: begin
                // Withdrawal outranks a simultaneous acknowledge.
                if (!gie || !irq_req[cur] || !imsk[cur]) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end else if (cpu_ack) begin
                    state_d = SERVICE;
                    irq_d   = 1'b0;
                end
            end
            SERVICE: begin
                if (cpu_reti) begin
                    state_d     = RELEASE;
                    exec_d      = '0;
                    exec_d[cur] = 1'b1;
                    cnt_d       = '0;
                end
            end
            RELEASE: begin
                if (!irq_req[cur]) begin
                    state_d = IDLE;
                    exec_d  = '0;
                end else if (cnt == 8'(EXEC_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    exec_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            imsk     <= '0;
            cur      <= '0;
            cpu_vec  <= '0;
            cpu_irq  <= 1'b0;
            irq_exec <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            imsk     <= imsk_d;
            cur      <= cur_d;
            cpu_vec  <= vec_d;
            cpu_irq  <= irq_d;
            irq_exec <= exec_d;
            cnt      <= cnt_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_intc_irq_responder.sv
// Self-checking bench for intc_irq_responder with randomized arbitration traffic.
module tb_intc_irq_responder;

    localparam int NSRC = 4;
    localparam int VEC_W = 2;
    localparam logic [7:0] AIMSK = 8'h3d;
    localparam logic [7:0] AIPND = 8'h3c;

    logic             clk = 1'b0;
    logic             rst;
    logic             write;
    logic [7:0]       addr;
    logic [7:0]       wdata;
    logic             read;
    logic [7:0]       rdata;
    logic [NSRC-1:0]  irq_req;
    logic [NSRC-1:0]  irq_exec;
    logic             gie;
    logic             cpu_irq;
    logic [VEC_W-1:0] cpu_vec;
    logic             cpu_ack;
    logic             cpu_reti;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    intc_irq_responder #(
        .NSRC         (NSRC),
        .EXEC_TIMEOUT (255)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .read     (read),
        .rdata    (rdata),
        .irq_req  (irq_req),
        .irq_exec (irq_exec),
        .gie      (gie),
        .cpu_irq  (cpu_irq),
        .cpu_vec  (cpu_vec),
        .cpu_ack  (cpu_ack),
        .cpu_reti (cpu_reti)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        write = 1'b1; addr = a; wdata = d;
        tick();
        write = 1'b0; addr = 8'h00; wdata = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        read = 1'b1; addr = a;
        #1;
        d = rdata;
        read = 1'b0; addr = 8'h00;
    endtask

    function automatic int lowest(input logic [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic pulse_ack();
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    endtask

    task automatic pulse_reti();
        cpu_reti = 1'b1; tick(); cpu_reti = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL reset_cpu_irq got=%b exp=0", cpu_irq); end
        total++; if (cpu_vec !== 2'd0) begin bad++; $display("FAIL reset_cpu_vec got=%0d exp=0", cpu_vec); end
        total++; if (irq_exec !== 4'b0) begin bad++; $display("FAIL reset_irq_exec got=%b exp=0000", irq_exec); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        bus_read(AIMSK, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_imsk got=%h exp=00", d); end
        bus_write(AIMSK, 8'h0f);
        bus_read(AIMSK, d);
        total++; if (d !== 8'h0f) begin bad++; $display("FAIL imsk_readback got=%h exp=0f", d); end
        bus_read(AIPND, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL ipnd_idle got=%h exp=00", d); end
        bus_write(8'h10, 8'h00);
        bus_read(AIMSK, d);
        total++; if (d !== 8'h0f) begin bad++; $display("FAIL other_addr_write got=%h exp=0f", d); end
    endtask

    task automatic test_basic();
        gie = 1'b1; irq_req = 4'b0110;
        tick();
        total++; if (cpu_irq !== 1'b1 || cpu_vec !== 2'd1) begin bad++; $display("FAIL basic_present got=%b/%0d exp=1/1", cpu_irq, cpu_vec); end
        irq_req = 4'b0111;  // higher priority arrival does not pre-empt
        tick();
        total++; if (cpu_irq !== 1'b1 || cpu_vec !== 2'd1) begin bad++; $display("FAIL basic_no_preempt got=%b/%0d exp=1/1", cpu_irq, cpu_vec); end
        irq_req = 4'b0110;
        pulse_ack();
        total++; if (cpu_irq !== 1'b0 || irq_exec !== 4'b0) begin bad++; $display("FAIL basic_ack got=%b/%b exp=0/0000", cpu_irq, irq_exec); end
        pulse_ack();
        repeat (3) tick();
        total++; if (cpu_irq !== 1'b0 || irq_exec !== 4'b0) begin bad++; $display("FAIL basic_service_wait got=%b/%b exp=0/0000", cpu_irq, irq_exec); end
        pulse_reti();
        total++; if (irq_exec !== 4'b0010) begin bad++; $display("FAIL basic_exec got=%b exp=0010", irq_exec); end
        tick();
        total++; if (irq_exec !== 4'b0010) begin bad++; $display("FAIL basic_exec_hold got=%b exp=0010", irq_exec); end
        irq_req = 4'b0100;
        tick();
        total++; if (irq_exec !== 4'b0000) begin bad++; $display("FAIL basic_exec_drop got=%b exp=0000", irq_exec); end
        tick();
        total++; if (cpu_irq !== 1'b1 || cpu_vec !== 2'd2) begin bad++; $display("FAIL basic_next got=%b/%0d exp=1/2", cpu_irq, cpu_vec); end
        pulse_ack(); pulse_reti();
        total++; if (irq_exec !== 4'b0100) begin bad++; $display("FAIL basic_exec2 got=%b exp=0100", irq_exec); end
        irq_req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_gie();
        gie = 1'b0; irq_req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL gie_blocked cyc=%0d got=%b exp=0", i, cpu_irq); end
        end
        gie = 1'b1;
        tick();
        total++; if (cpu_irq !== 1'b1 || cpu_vec !== 2'd0) begin bad++; $display("FAIL gie_raise got=%b/%0d exp=1/0", cpu_irq, cpu_vec); end
        gie = 1'b0;
        tick();
        total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL gie_withdraw got=%b exp=0", cpu_irq); end
        irq_req = 4'b0000; gie = 1'b1;
        tick();
    endtask

    task automatic test_withdraw();
        irq_req = 4'b0001;
        tick();
        total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL wd_req_present got=%b exp=1", cpu_irq); end
        irq_req = 4'b0000;
        tick();
        total++; if (cpu_irq !== 1'b0 || irq_exec !== 4'b0) begin bad++; $display("FAIL wd_req_drop got=%b/%b exp=0/0000", cpu_irq, irq_exec); end
        irq_req = 4'b0001;
        tick();
        total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL wd_mask_present got=%b exp=1", cpu_irq); end
        bus_write(AIMSK, 8'h0e);
        tick();
        total++; if (cpu_irq !== 1'b0 || irq_exec !== 4'b0) begin bad++; $display("FAIL wd_mask_drop got=%b/%b exp=0/0000", cpu_irq, irq_exec); end
        repeat (3) tick();
        total++; if (cpu_irq !== 1'b0 || irq_exec !== 4'b0) begin bad++; $display("FAIL wd_masked_idle got=%b/%b exp=0/0000", cpu_irq, irq_exec); end
        irq_req = 4'b0000;
        bus_write(AIMSK, 8'h0f);
    endtask

    task automatic test_random();
        logic [NSRC-1:0] m, r, exp_exec;
        int w, hold;
        for (int it = 0; it < 40; it++) begin
            m = NSRC'($urandom_range(0, 15));
            r = NSRC'($urandom_range(0, 15));
            bus_write(AIMSK, {4'h0, m});
            irq_req = r;
            tick();
            w = lowest(r & m);
            total++; if (cpu_irq !== (w >= 0)) begin bad++; $display("FAIL rnd_irq it=%0d m=%b r=%b got=%b", it, m, r, cpu_irq); end
            if (w >= 0) begin
                total++; if (cpu_vec !== VEC_W'(w)) begin bad++; $display("FAIL rnd_vec it=%0d got=%0d exp=%0d", it, cpu_vec, w); end
                repeat ($urandom_range(0, 3)) tick();
                pulse_ack();
                repeat ($urandom_range(0, 3)) tick();
                pulse_reti();
                exp_exec = '0; exp_exec[w] = 1'b1;
                hold = $urandom_range(0, 5);
                for (int h = 0; h <= hold; h++) begin
                    total++; if (irq_exec !== exp_exec) begin bad++; $display("FAIL rnd_exec it=%0d got=%b exp=%b", it, irq_exec, exp_exec); end
                    if (h < hold) tick();
                end
                irq_req = '0;
                tick();
                total++; if (irq_exec !== 4'b0 || cpu_irq !== 1'b0) begin bad++; $display("FAIL rnd_release it=%0d got=%b/%b exp=0000/0", it, irq_exec, cpu_irq); end
            end else begin
                irq_req = '0;
                tick();
            end
        end
        bus_write(AIMSK, 8'h0f);
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        int cycles;
        irq_req = 4'b0001;
        tick(); pulse_ack(); pulse_reti();
        gie = 1'b0;
        total++; if (irq_exec !== 4'b0001) begin bad++; $display("FAIL to_exec got=%b exp=0001", irq_exec); end
        cycles = 0;
        while (irq_exec !== 4'b0 && cycles < 400) begin
            tick();
            cycles++;
        end
        total++; if (cycles !== 255) begin bad++; $display("FAIL to_cycles got=%0d exp=255", cycles); end
        bus_read(AIPND, d);
        total++; if (d !== 8'h81) begin bad++; $display("FAIL to_err_set got=%h exp=81", d); end
        tick();
        bus_read(AIPND, d);
        total++; if (d !== 8'h81) begin bad++; $display("FAIL to_err_sticky got=%h exp=81", d); end
        bus_write(AIPND, 8'h80);
        bus_read(AIPND, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL to_err_clear got=%h exp=01", d); end
        irq_req = 4'b0000; gie = 1'b1;
        tick();
    endtask

    task automatic test_reset_release();
        logic [7:0] d;
        irq_req = 4'b0100;
        tick(); pulse_ack(); pulse_reti();
        total++; if (irq_exec !== 4'b0100) begin bad++; $display("FAIL rr_exec got=%b exp=0100", irq_exec); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (irq_exec !== 4'b0 || cpu_irq !== 1'b0 || cpu_vec !== 2'd0) begin
            bad++; $display("FAIL rr_outputs got=%b/%b/%0d exp=0000/0/0", irq_exec, cpu_irq, cpu_vec);
        end
        bus_read(AIMSK, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rr_imsk got=%h exp=00", d); end
        tick();
        total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL rr_masked got=%b exp=0", cpu_irq); end
        irq_req = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; addr = 8'h00; wdata = 8'h00; read = 1'b0;
        irq_req = '0; gie = 1'b0; cpu_ack = 1'b0; cpu_reti = 1'b0;
        test_reset();
        test_basic();
        test_gie();
        test_withdraw();
        test_random();
        test_timeout();
        test_reset_release();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end

endmodule
